srv32_dmem_wbuf: RTL

//  Posted-write buffer on the srv32_core data-memory port, between core dmem_* and the data RAM/bus.

---
 rtl/srv32_dmem_wbuf.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/srv32_dmem_wbuf.sv
// ---------------------------------------------------------------------------
// srv32_dmem_wbuf
// Posted-write buffer on the srv32_core data-memory port.
//
// Core stores go into a DEPTH-entry FIFO in one cycle. They drain to memory
// in order from the FIFO head. A load is forwarded to memory only when no
// buffered (or same-cycle) store can alias it, so RAW order is preserved.
// Read responses pass straight back to the core.
//
// Optional feature macro: SRV32_WBUF_FWD_EN
//   undefined : loads wait until the FIFO is empty and no store is pending.
//   defined   : loads bypass buffered stores to other words. No data
//               forwarding is done.
//
// Ports
//   clk, resetb                      clock, async active-low reset
//   core_wready/core_wvalid          store request / store accepted
//   core_waddr/core_wdata/core_wstrb store payload
//   core_rready/core_rvalid          load request / load accepted
//   core_raddr                       load address
//   core_rresp/core_rdata            load response (from memory)
//   mem_wready/mem_wvalid            write request / memory accepts write
//   mem_waddr/mem_wdata/mem_wstrb    FIFO head entry
//   mem_rready/mem_rvalid            read request / memory accepts read
//   mem_raddr                        read address (= core_raddr)
//   mem_rresp/mem_rdata              read response from memory
//
// While resetb is low, every output is forced to 0.
// ---------------------------------------------------------------------------
module srv32_dmem_wbuf #(
    parameter int DEPTH = 4,
    parameter int AW    = 32
) (
    input  logic          clk,
    input  logic          resetb,
    input  logic          core_wready,
    output logic          core_wvalid,
    input  logic [AW-1:0] core_waddr,
    input  logic [31:0]   core_wdata,
    input  logic [3:0]    core_wstrb,
    input  logic          core_rready,
    output logic          core_rvalid,
    input  logic [AW-1:0] core_raddr,
    output logic          core_rresp,
    output logic [31:0]   core_rdata,
    output logic          mem_wready,
    input  logic          mem_wvalid,
    output logic [AW-1:0] mem_waddr,
    output logic [31:0]   mem_wdata,
    output logic [3:0]    mem_wstrb,
    output logic          mem_rready,
    input  logic          mem_rvalid,
    output logic [AW-1:0] mem_raddr,
    input  logic          mem_rresp,
    input  logic [31:0]   mem_rdata
);

    localparam int          PW       = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_WAIT = 1'b1
    } rstate_t;

    logic [AW-1:0] r_addr [DEPTH];
    logic [31:0]   r_data [DEPTH];
    logic [3:0]    r_strb [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW:0]   r_count;
    rstate_t       r_rstate;
    rstate_t       w_rstate_nxt;

    logic w_live;
    logic w_not_full;
    logic w_not_empty;
    logic w_push;
    logic w_pop;
    logic w_rd_clear;
    logic w_mem_rready;
    logic w_rd_xfer;

    // Outputs are held at 0 while reset is asserted.
    assign w_live      = resetb;
    assign w_not_full  = (r_count != FULL_CNT);
    assign w_not_empty = (r_count != {(PW+1){1'b0}});
    assign w_push      = core_wready & w_not_full;
    assign w_pop       = w_not_empty & mem_wvalid;

`ifdef SRV32_WBUF_FWD_EN
    logic w_alias_buf;

    // Word-address match against every live FIFO entry. An entry is live
    // when its distance from the read pointer is below the occupancy.
    always_comb begin
        w_alias_buf = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            w_alias_buf = w_alias_buf |
                (({1'b0, (PW'(i) - r_rd_ptr)} < r_count) &
                 (r_addr[i][AW-1:2] == core_raddr[AW-1:2]));
        end
    end

    // A store presented in the same cycle is older than the load.
    assign w_rd_clear = ~w_alias_buf &
                        ~(core_wready & (core_waddr[AW-1:2] == core_raddr[AW-1:2]));
`else
    // Base rule: a load waits for a full drain and no pending store.
    assign w_rd_clear = ~w_not_empty & ~core_wready;
`endif

    assign w_mem_rready = w_live & core_rready & (r_rstate == R_IDLE) & w_rd_clear;
    assign w_rd_xfer    = w_mem_rready & mem_rvalid;

    assign core_wvalid = w_live & w_not_full;
    assign mem_wready  = w_live & w_not_empty;
    assign mem_waddr   = w_live ? r_addr[r_rd_ptr] : {AW{1'b0}};
    assign mem_wdata   = w_live ? r_data[r_rd_ptr] : 32'h0000_0000;
    assign mem_wstrb   = w_live ? r_strb[r_rd_ptr] : 4'h0;
    assign mem_rready  = w_mem_rready;
    assign core_rvalid = w_rd_xfer;
    assign mem_raddr   = w_live ? core_raddr : {AW{1'b0}};
    assign core_rresp  = w_live & mem_rresp;
    assign core_rdata  = w_live ? mem_rdata : 32'h0000_0000;

    // Store FIFO: storage, pointers and occupancy.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_addr[i] <= {AW{1'b0}};
                r_data[i] <= 32'h0000_0000;
                r_strb[i] <= 4'h0;
            end
            r_wr_ptr <= {PW{1'b0}};
            r_rd_ptr <= {PW{1'b0}};
            r_count  <= {(PW+1){1'b0}};
        end else begin
            if (w_push) begin
                r_addr[r_wr_ptr] <= core_waddr;
                r_data[r_wr_ptr] <= core_wdata;
                r_strb[r_wr_ptr] <= core_wstrb;
                r_wr_ptr         <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PW+1)'(1);
                2'b01:   r_count <= r_count - (PW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Read FSM state register.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_rstate <= R_IDLE;
        end else begin
            r_rstate <= w_rstate_nxt;
        end
    end

    // Read FSM next state: one outstanding load. A response seen in
    // R_IDLE is a protocol error and is ignored.
    always_comb begin
        w_rstate_nxt = r_rstate;
        case (r_rstate)
            R_IDLE: begin
                if (w_rd_xfer) begin
                    w_rstate_nxt = R_WAIT;
                end else begin
                    w_rstate_nxt = R_IDLE;
                end
            end
            R_WAIT: begin
                if (mem_rresp) begin
                    w_rstate_nxt = R_IDLE;
                end else begin
                    w_rstate_nxt = R_WAIT;
                end
            end
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

endmodule
